jk_bank_driver: RTL

//  Drives a bank of WIDTH JK flip-flops toward target words; it is the command side of
//  the JK flop interface. Each accepted target word is converted to per-bit J/K commands

---
 rtl/jk_bank_driver.sv | 133 +++++++++++++
 1 files changed

// File: rtl/jk_bank_driver.sv
`default_nettype none
// ============================================================================
// Module   : jk_bank_driver
// Brief    : Converts target words into J/K commands for a bank of JK flops
//            and re-drives the bank on q-feedback mismatch.
// Revision : 1.0 - initial release
// ============================================================================
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int TOGGLE_EN = 0,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] err_count
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] C_MAX_RETRY = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_tgt;
    logic [RETRY_W-1:0] r_retry;
    logic [WIDTH-1:0]   r_j;
    logic [WIDTH-1:0]   r_k;
    logic               r_done;
    logic               r_mismatch;
    logic               r_in_ready;
    logic [CNT_W-1:0]   r_err_count;

    // The encoder target is the new word while idle, otherwise the held target.
    logic [WIDTH-1:0] w_enc_src;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_enc_j;
    logic [WIDTH-1:0] w_enc_k;

    assign w_enc_src = (r_state == S_IDLE) ? in_data : r_tgt;
    assign w_diff    = w_enc_src ^ q_fb;

    generate
        if (TOGGLE_EN != 0) begin : g_toggle
            assign w_enc_j = w_diff;
            assign w_enc_k = w_diff;
        end else begin : g_set_reset
            assign w_enc_j = w_diff & w_enc_src;
            assign w_enc_k = w_diff & ~w_enc_src;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tgt       <= '0;
            r_retry     <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_done      <= 1'b0;
            r_mismatch  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_err_count <= '0;
        end else begin
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_tgt      <= in_data;
                        r_retry    <= '0;
                        r_j        <= w_enc_j;
                        r_k        <= w_enc_k;
                        r_in_ready <= 1'b0;
                        r_state    <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    r_j     <= '0;
                    r_k     <= '0;
                    r_state <= S_CHECK;
                end
                S_CHECK: begin
                    if (q_fb == r_tgt) begin
                        r_done     <= 1'b1;
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_retry < C_MAX_RETRY) begin
                        r_retry <= r_retry + 1'b1;
                        r_j     <= w_enc_j;
                        r_k     <= w_enc_k;
                        r_state <= S_DRIVE;
                    end else begin
                        r_done     <= 1'b1;
                        r_mismatch <= 1'b1;
                        r_in_ready <= 1'b1;
                        if (r_err_count != {CNT_W{1'b1}}) begin
                            r_err_count <= r_err_count + 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_j        <= '0;
                    r_k        <= '0;
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign jk_j      = r_j;
    assign jk_k      = r_k;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign err_count = r_err_count;

endmodule
`default_nettype wire
